// File: rtl/sixty_four_bit_demux_buffer.sv
// sixty_four_bit_demux_buffer: routes one source word to channel A or B, each a small valid/ready FIFO.
// Defining DEMUX_STATS_EN adds saturating per-channel pop counters and an input stall counter.
module sixty_four_bit_demux_buffer #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sel,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   a_valid,
    input  logic                   a_ready,
    output logic [WIDTH-1:0]       a_data,
    output logic                   b_valid,
    input  logic                   b_ready,
    output logic [WIDTH-1:0]       b_data,
    output logic [$clog2(DEPTH):0] a_count,
    output logic [$clog2(DEPTH):0] b_count
`ifdef DEMUX_STATS_EN
    ,
    output logic [31:0]            a_xfer_cnt,
    output logic [31:0]            b_xfer_cnt,
    output logic [31:0]            stall_cnt
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;
    logic [1:0] rdy, vld, full, push, pop;
    logic [1:0][WIDTH-1:0] dout;
    logic [1:0][CW-1:0] cnt;
    assign rdy = {b_ready, a_ready};
    // Acceptance looks only at registered fullness, so a same-cycle pop never frees a slot.
    assign in_ready = !reset && !full[in_sel];
    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [WIDTH-1:0] mem_q [DEPTH];
        logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
        logic [CW-1:0] cnt_q, cnt_d;
        state_t st_q, st_d;
        assign push[c] = in_valid && in_ready && (in_sel == (c != 0));
        assign pop[c]  = vld[c] && rdy[c];
        assign vld[c]  = st_q != EMPTY;
        assign full[c] = st_q == FULL;
        assign dout[c] = mem_q[rd_q];
        assign cnt[c]  = cnt_q;
        always_comb begin
            wr_d  = push[c] ? wr_q + 1'b1 : wr_q;
            rd_d  = pop[c] ? rd_q + 1'b1 : rd_q;
            cnt_d = (push[c] && !pop[c]) ? cnt_q + 1'b1 :
                    (pop[c] && !push[c]) ? cnt_q - 1'b1 : cnt_q;
            st_d  = (cnt_d == '0) ? EMPTY : (cnt_d == CW'(DEPTH)) ? FULL : PARTIAL;
        end
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
                st_q  <= EMPTY;
            end else begin
                if (push[c]) mem_q[wr_q] <= in_data;
                wr_q  <= wr_d;
                rd_q  <= rd_d;
                cnt_q <= cnt_d;
                st_q  <= st_d;
            end
        end
    end
    assign a_valid = vld[0];
    assign a_data  = dout[0];
    assign a_count = cnt[0];
    assign b_valid = vld[1];
    assign b_data  = dout[1];
    assign b_count = cnt[1];
`ifdef DEMUX_STATS_EN
    logic [31:0] a_xfer_q, b_xfer_q, stall_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            a_xfer_q <= '0;
            b_xfer_q <= '0;
            stall_q  <= '0;
        end else begin
            a_xfer_q <= a_xfer_q + 32'(pop[0] && a_xfer_q != '1);
            b_xfer_q <= b_xfer_q + 32'(pop[1] && b_xfer_q != '1);
            stall_q  <= stall_q + 32'(in_valid && !in_ready && stall_q != '1);
        end
    end
    assign a_xfer_cnt = a_xfer_q;
    assign b_xfer_cnt = b_xfer_q;
    assign stall_cnt  = stall_q;
`endif
endmodule

// File: tb/tb_sixty_four_bit_demux_buffer.sv
// tb_sixty_four_bit_demux_buffer: vector table, directed corner sequences and random traffic
// checked against a queue-based model of the two channels.
module tb_sixty_four_bit_demux_buffer;
    localparam int DEPTH = 2;
    localparam bit Y = 1'b1;
    localparam bit N = 1'b0;
    logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, in_sel = 1'b0, a_ready = 1'b0, b_ready = 1'b0;
    logic [63:0] in_data = '0;
    logic in_ready, a_valid, b_valid;
    logic [63:0] a_data, b_data;
    logic [1:0] a_count, b_count;
`ifdef DEMUX_STATS_EN
    logic [31:0] a_xfer_cnt, b_xfer_cnt, stall_cnt;
    int m_ax = 0, m_bx = 0, m_st = 0;
`endif
    int checks = 0, failures = 0;
    logic [63:0] qa[$], qb[$];

    typedef struct {
        logic v, s; logic [63:0] d; logic ar, br;
        logic rdy, av; logic [63:0] ad; logic [1:0] ac;
        logic bv; logic [63:0] bd; logic [1:0] bc;
    } vec_t;
    vec_t tbl[9];

    always #5 clk = ~clk;

    sixty_four_bit_demux_buffer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
        .in_data(in_data), .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .a_count(a_count), .b_count(b_count)
`ifdef DEMUX_STATS_EN
        , .a_xfer_cnt(a_xfer_cnt), .b_xfer_cnt(b_xfer_cnt), .stall_cnt(stall_cnt)
`endif
    );

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    task automatic check_state();
        chk("a_valid", 64'(a_valid), 64'(qa.size() != 0));
        chk("a_count", 64'(a_count), 64'(qa.size()));
        if (qa.size() != 0) chk("a_data", a_data, qa[0]);
        chk("b_valid", 64'(b_valid), 64'(qb.size() != 0));
        chk("b_count", 64'(b_count), 64'(qb.size()));
        if (qb.size() != 0) chk("b_data", b_data, qb[0]);
`ifdef DEMUX_STATS_EN
        chk("a_xfer_cnt", 64'(a_xfer_cnt), 64'(m_ax));
        chk("b_xfer_cnt", 64'(b_xfer_cnt), 64'(m_bx));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_st));
`endif
    endtask

    task automatic cycle(input logic v, input logic s, input logic [63:0] d, input logic ar, input logic br);
        logic rdy;
        in_valid = v; in_sel = s; in_data = d; a_ready = ar; b_ready = br;
        #1;
        rdy = s ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
        chk("in_ready", 64'(in_ready), 64'(rdy));
`ifdef DEMUX_STATS_EN
        if (ar && qa.size() != 0) m_ax++;
        if (br && qb.size() != 0) m_bx++;
        if (v && !rdy) m_st++;
`endif
        if (ar && qa.size() != 0) void'(qa.pop_front());
        if (br && qb.size() != 0) void'(qb.pop_front());
        if (v && rdy) begin
            if (s) qb.push_back(d);
            else qa.push_back(d);
        end
        @(posedge clk); #1;
        check_state();
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
        #1;
        chk("in_ready_in_reset", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        qa.delete();
        qb.delete();
`ifdef DEMUX_STATS_EN
        m_ax = 0; m_bx = 0; m_st = 0;
`endif
        chk("a_data_rst", a_data, 64'd0);
        chk("b_data_rst", b_data, 64'd0);
        check_state();
    endtask

    initial begin
        tbl[0] = '{Y, N, 64'h0, N, N, Y, Y, 64'h0, 2'd1, N, 64'h0, 2'd0};
        tbl[1] = '{Y, Y, 64'hFFFF_FFFF_FFFF_FFFF, N, N, Y, Y, 64'h0, 2'd1, Y, 64'hFFFF_FFFF_FFFF_FFFF, 2'd1};
        tbl[2] = '{Y, Y, 64'h1, N, N, Y, Y, 64'h0, 2'd1, Y, 64'hFFFF_FFFF_FFFF_FFFF, 2'd2};
        tbl[3] = '{Y, Y, 64'h2, N, N, N, Y, 64'h0, 2'd1, Y, 64'hFFFF_FFFF_FFFF_FFFF, 2'd2};
        tbl[4] = '{N, N, 64'h0, N, N, Y, Y, 64'h0, 2'd1, Y, 64'hFFFF_FFFF_FFFF_FFFF, 2'd2};
        tbl[5] = '{Y, Y, 64'h3, N, Y, N, Y, 64'h0, 2'd1, Y, 64'h1, 2'd1};
        tbl[6] = '{Y, N, 64'h7, Y, Y, Y, Y, 64'h7, 2'd1, N, 64'h0, 2'd0};
        tbl[7] = '{N, N, 64'h0, Y, N, Y, N, 64'h0, 2'd0, N, 64'h0, 2'd0};
        tbl[8] = '{Y, Y, 64'h55, N, Y, Y, N, 64'h0, 2'd0, Y, 64'h55, 2'd1};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            in_valid = tbl[i].v; in_sel = tbl[i].s; in_data = tbl[i].d;
            a_ready = tbl[i].ar; b_ready = tbl[i].br;
            #1;
            chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].rdy));
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_a_valid", i), 64'(a_valid), 64'(tbl[i].av));
            chk($sformatf("tbl%0d_a_count", i), 64'(a_count), 64'(tbl[i].ac));
            if (tbl[i].av) chk($sformatf("tbl%0d_a_data", i), a_data, tbl[i].ad);
            chk($sformatf("tbl%0d_b_valid", i), 64'(b_valid), 64'(tbl[i].bv));
            chk($sformatf("tbl%0d_b_count", i), 64'(b_count), 64'(tbl[i].bc));
            if (tbl[i].bv) chk($sformatf("tbl%0d_b_data", i), b_data, tbl[i].bd);
        end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(Y, N, 64'hA0 + 64'(i), Y, N);
            chk("wrap_a_data", a_data, 64'hA0 + 64'(i));
        end
        cycle(N, N, 64'h0, Y, N);
        chk("wrap_a_count_end", 64'(a_count), 64'd0);
        do_reset();
        cycle(Y, N, 64'h11, N, N);
        cycle(Y, N, 64'h22, N, N);
        chk("mid_a_count", 64'(a_count), 64'd2);
        do_reset();
        chk("mid_rst_a_valid", 64'(a_valid), 64'd0);
        cycle(Y, N, 64'h5, N, N);
        chk("post_rst_a_data", a_data, 64'h5);
        chk("post_rst_a_count", 64'(a_count), 64'd1);
`ifdef DEMUX_STATS_EN
        do_reset();
        cycle(Y, N, 64'h1, N, N);
        cycle(Y, N, 64'h2, N, N);
        for (int i = 0; i < 3; i++) cycle(Y, N, 64'h3, N, N);
        cycle(N, N, 64'h0, Y, N);
        cycle(N, N, 64'h0, Y, N);
        chk("stats_stall", 64'(stall_cnt), 64'd3);
        chk("stats_a_xfer", 64'(a_xfer_cnt), 64'd2);
        chk("stats_b_xfer", 64'(b_xfer_cnt), 64'd0);
`endif
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            else cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, {$urandom(), $urandom()},
                       $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
